// File: rtl/mem_boot_loader_if.sv
// Stream-in and memory-write bundle for the boot loader.
// The slave modport is the loader's side; the master modport is the stream source and memory side.
interface mem_boot_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, dmem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_boot_loader.sv
// Front-door image loader: parses header/base/payload blocks from a word stream into imem/dmem
// writes and holds the core in reset until the end-of-image header is taken.
module mem_boot_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_boot_loader_if.slave       bus,
    output logic                   core_reset,
    output logic                   done,
    output logic                   wrap_err
);
    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              target_q, target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_pend_q, wrap_pend_d;
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              wrap_err_q, wrap_err_d;
    logic              fire;

    assign fire = bus.in_valid && ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        wrap_pend_d  = wrap_pend_q;
        imem_we_d    = 1'b0;
        dmem_we_d    = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        wrap_err_d   = wrap_err_q;

        case (state_q)
            S_HDR: begin
                if (fire) begin
                    target_d = bus.in_data[31];
                    cnt_d    = bus.in_data[CNT_W-1:0];
                    if (bus.in_data[CNT_W-1:0] == '0) begin
                        state_d      = S_DONE;
                        core_reset_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (fire) begin
                    ptr_d       = bus.in_data[ADDR_W-1:0];
                    wrap_pend_d = 1'b0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (fire) begin
                    imem_we_d   = ~target_q;
                    dmem_we_d   = target_q;
                    addr_d      = ptr_q;
                    wdata_d     = bus.in_data;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    cnt_d       = cnt_q - CNT_W'(1);
                    // previous write of this block sat at the top address, so this one wrapped
                    wrap_pend_d = (ptr_q == '1);
                    wrap_err_d  = wrap_err_q | wrap_pend_q;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HDR;
            ready_q      <= 1'b0;
            target_q     <= 1'b0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            wrap_pend_q  <= 1'b0;
            imem_we_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            wrap_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            target_q     <= target_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            wrap_pend_q  <= wrap_pend_d;
            imem_we_q    <= imem_we_d;
            dmem_we_q    <= dmem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            wrap_err_q   <= wrap_err_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.imem_we   = imem_we_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign core_reset    = core_reset_q;
    assign done          = done_q;
    assign wrap_err      = wrap_err_q;
endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: a 10-bit-address instance for loads/reset
// and a 4-bit-address instance for the address-wrap case.
module tb_mem_boot_loader;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic core_reset_a, done_a, wrap_a;
    logic core_reset_b, done_b, wrap_b;

    mem_boot_loader_if #(.ADDR_W(10)) ia ();
    mem_boot_loader_if #(.ADDR_W(4))  ib ();

    mem_boot_loader #(.ADDR_W(10), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ia),
        .core_reset(core_reset_a), .done(done_a), .wrap_err(wrap_a)
    );
    mem_boot_loader #(.ADDR_W(4), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ib),
        .core_reset(core_reset_b), .done(done_b), .wrap_err(wrap_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          i;
        bit          d;
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t log_a[$];
    wr_t log_b[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_ready = 1'b0;
    int  ready_drops = 0;

    // Write-strobe recorder, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ia.imem_we || ia.dmem_we)
            log_a.push_back(wr_t'{i: ia.imem_we, d: ia.dmem_we, addr: ia.mem_addr, data: ia.mem_wdata, cyc: cyc});
        if (ib.imem_we || ib.dmem_we)
            log_b.push_back(wr_t'{i: ib.imem_we, d: ib.dmem_we, addr: 10'(ib.mem_addr), data: ib.mem_wdata, cyc: cyc});
        if (mon_ready && !ia.in_ready) ready_drops = ready_drops + 1;
    end

    task automatic send(input bit sel, input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        if (sel) begin ib.in_valid = 1'b1; ib.in_data = w; end
        else     begin ia.in_valid = 1'b1; ia.in_data = w; end
        checks++;
        while (!(sel ? ib.in_ready : ia.in_ready)) begin
            n++;
            if (n > 50) begin
                errors++;
                $display("FAIL send_timeout: word %h not taken, in_ready got 0 required 1", w);
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit sel, input int n);
        @(negedge clk);
        if (sel) ib.in_valid = 1'b0; else ia.in_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset(input bit sel);
        @(negedge clk);
        if (sel) begin rst_b = 1'b0; ib.in_valid = 1'b0; end
        else     begin rst_a = 1'b0; ia.in_valid = 1'b0; end
        @(negedge clk);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ia.in_valid = 1'b0; ia.in_data = '0;
        ib.in_valid = 1'b0; ib.in_data = '0;
        #2; rst_a = 1'b0; rst_b = 1'b0;
        #1;
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", ia.in_ready); end
        checks++; if ({ia.imem_we, ia.dmem_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b required 00", {ia.imem_we, ia.dmem_we}); end
        checks++; if (ia.mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", ia.mem_addr); end
        checks++; if (ia.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h required 0", ia.mem_wdata); end
        checks++; if ({core_reset_a, done_a, wrap_a} !== 3'b100) begin errors++; $display("FAIL reset_status: got %b required 100", {core_reset_a, done_a, wrap_a}); end
        checks++; if ({core_reset_b, done_b, wrap_b, ib.in_ready} !== 4'b1000) begin errors++; $display("FAIL reset_status_b: got %b required 1000", {core_reset_b, done_b, wrap_b, ib.in_ready}); end
        @(posedge clk); #1;
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL reset_held_ready: got %b required 0", ia.in_ready); end
        @(negedge clk); rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ia.in_ready, ib.in_ready} !== 2'b11) begin errors++; $display("FAIL reset_release_ready: got %b required 11", {ia.in_ready, ib.in_ready}); end
    endtask

    task automatic test_imem_load;
        log_a.delete();
        send(0, 32'h0000_0002); send(0, 32'h0000_0000);
        send(0, 32'h2001_0007); send(0, 32'h2002_0100);
        checks++; if ({core_reset_a, done_a} !== 2'b10) begin errors++; $display("FAIL imem_pre_release: got %b required 10", {core_reset_a, done_a}); end
        send(0, 32'h0000_0000);
        checks++; if ({core_reset_a, done_a, ia.in_ready} !== 3'b010) begin errors++; $display("FAIL imem_release: got %b required 010", {core_reset_a, done_a, ia.in_ready}); end
        idle(0, 2);
        checks++; if (log_a.size() !== 2) begin errors++; $display("FAIL imem_count: got %0d writes required 2", log_a.size()); end
        if (log_a.size() == 2) begin
            checks++; if ({log_a[0].i, log_a[0].d, log_a[0].addr, log_a[0].data} !== {2'b10, 10'd0, 32'h2001_0007}) begin errors++; $display("FAIL imem_wr0: got i%b d%b %h=%h required i1 d0 000=20010007", log_a[0].i, log_a[0].d, log_a[0].addr, log_a[0].data); end
            checks++; if ({log_a[1].i, log_a[1].d, log_a[1].addr, log_a[1].data} !== {2'b10, 10'd1, 32'h2002_0100}) begin errors++; $display("FAIL imem_wr1: got i%b d%b %h=%h required i1 d0 001=20020100", log_a[1].i, log_a[1].d, log_a[1].addr, log_a[1].data); end
            checks++; if (log_a[1].cyc !== log_a[0].cyc + 1) begin errors++; $display("FAIL imem_b2b: got cycle gap %0d required 1", log_a[1].cyc - log_a[0].cyc); end
        end
    endtask

    task automatic test_dmem_gaps;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h100; exp_d[1] = 32'h200; exp_d[2] = 32'h150;
        do_reset(0);
        log_a.delete();
        ready_drops = 0; mon_ready = 1'b1;
        send(0, 32'h8000_0003); idle(0, 2);
        send(0, 32'h0000_0003); idle(0, 2);
        for (int k = 0; k < 3; k++) begin send(0, exp_d[k]); idle(0, 2); end
        mon_ready = 1'b0;
        checks++; if (ready_drops !== 0) begin errors++; $display("FAIL dmem_ready: got %0d cycles with in_ready=0 required 0", ready_drops); end
        checks++; if (log_a.size() !== 3) begin errors++; $display("FAIL dmem_count: got %0d writes required 3", log_a.size()); end
        if (log_a.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({log_a[k].i, log_a[k].d, log_a[k].addr, log_a[k].data} !== {2'b01, 10'(k + 3), exp_d[k]}) begin
                    errors++;
                    $display("FAIL dmem_wr%0d: got i%b d%b %h=%h required i0 d1 %h=%h", k, log_a[k].i, log_a[k].d, log_a[k].addr, log_a[k].data, 10'(k + 3), exp_d[k]);
                end
            end
        end
        send(0, 32'h0000_0000);
        checks++; if ({core_reset_a, done_a} !== 2'b01) begin errors++; $display("FAIL dmem_release: got %b required 01", {core_reset_a, done_a}); end
        idle(0, 1);
    endtask

    task automatic test_wrap;
        log_b.delete();
        send(1, 32'h8000_0003); send(1, 32'h0000_000E);
        send(1, 32'd1); send(1, 32'd2);
        checks++; if (wrap_b !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b required 0", wrap_b); end
        send(1, 32'd3);
        checks++; if (wrap_b !== 1'b1) begin errors++; $display("FAIL wrap_set: got %b required 1", wrap_b); end
        send(1, 32'h0000_0000);
        idle(1, 3);
        checks++; if ({done_b, core_reset_b, wrap_b} !== 3'b101) begin errors++; $display("FAIL wrap_after_done: got %b required 101", {done_b, core_reset_b, wrap_b}); end
        checks++; if (log_b.size() !== 3) begin errors++; $display("FAIL wrap_count: got %0d writes required 3", log_b.size()); end
        if (log_b.size() == 3) begin
            checks++; if ({log_b[0].d, log_b[0].addr, log_b[0].data} !== {1'b1, 10'hE, 32'd1}) begin errors++; $display("FAIL wrap_wr0: got d%b %h=%h required d1 00e=1", log_b[0].d, log_b[0].addr, log_b[0].data); end
            checks++; if ({log_b[1].d, log_b[1].addr, log_b[1].data} !== {1'b1, 10'hF, 32'd2}) begin errors++; $display("FAIL wrap_wr1: got d%b %h=%h required d1 00f=2", log_b[1].d, log_b[1].addr, log_b[1].data); end
            checks++; if ({log_b[2].d, log_b[2].addr, log_b[2].data} !== {1'b1, 10'h0, 32'd3}) begin errors++; $display("FAIL wrap_wr2: got d%b %h=%h required d1 000=3", log_b[2].d, log_b[2].addr, log_b[2].data); end
        end
    endtask

    task automatic test_empty_image;
        do_reset(0);
        log_a.delete();
        send(0, 32'h0000_0000);
        checks++; if ({core_reset_a, done_a, ia.in_ready} !== 3'b010) begin errors++; $display("FAIL empty_release: got %b required 010", {core_reset_a, done_a, ia.in_ready}); end
        idle(0, 3);
        checks++; if (log_a.size() !== 0) begin errors++; $display("FAIL empty_writes: got %0d writes required 0", log_a.size()); end
    endtask

    task automatic test_done_hold;
        @(negedge clk); ia.in_valid = 1'b1; ia.in_data = 32'h8000_0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL done_ready%0d: got %b required 0", k, ia.in_ready); end
        end
        ia.in_valid = 1'b0;
        checks++; if (log_a.size() !== 0) begin errors++; $display("FAIL done_writes: got %0d writes required 0", log_a.size()); end
        checks++; if ({done_a, core_reset_a} !== 2'b10) begin errors++; $display("FAIL done_hold: got %b required 10", {done_a, core_reset_a}); end
    endtask

    task automatic test_mid_reset;
        do_reset(0);
        log_a.delete();
        send(0, 32'h0000_0004); send(0, 32'h0000_0010);
        send(0, 32'h0000_00A1); send(0, 32'h0000_00A2);
        @(negedge clk); ia.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_a = 1'b0;
        #1;
        checks++; if ({ia.in_ready, ia.imem_we, ia.dmem_we} !== 3'b000) begin errors++; $display("FAIL midrst_ctrl: got %b required 000", {ia.in_ready, ia.imem_we, ia.dmem_we}); end
        checks++; if ({ia.mem_addr, ia.mem_wdata} !== 42'd0) begin errors++; $display("FAIL midrst_bus: got %h/%h required 0/0", ia.mem_addr, ia.mem_wdata); end
        checks++; if ({core_reset_a, done_a, wrap_a} !== 3'b100) begin errors++; $display("FAIL midrst_status: got %b required 100", {core_reset_a, done_a, wrap_a}); end
        checks++; if (log_a.size() !== 2) begin errors++; $display("FAIL midrst_old: got %0d writes required 2", log_a.size()); end
        @(negedge clk); rst_a = 1'b1;
        @(posedge clk); #1;
        send(0, 32'h0000_0001); send(0, 32'h0000_0020);
        send(0, 32'h0000_ABCD); send(0, 32'h0000_0000);
        idle(0, 3);
        checks++; if (log_a.size() !== 3) begin errors++; $display("FAIL midrst_count: got %0d writes required 3", log_a.size()); end
        if (log_a.size() == 3) begin
            checks++; if ({log_a[0].addr, log_a[0].data, log_a[1].addr, log_a[1].data} !== {10'h10, 32'hA1, 10'h11, 32'hA2}) begin errors++; $display("FAIL midrst_kept: got %h=%h %h=%h required 010=a1 011=a2", log_a[0].addr, log_a[0].data, log_a[1].addr, log_a[1].data); end
            checks++; if ({log_a[2].i, log_a[2].d, log_a[2].addr, log_a[2].data} !== {2'b10, 10'h20, 32'hABCD}) begin errors++; $display("FAIL midrst_new: got i%b d%b %h=%h required i1 d0 020=abcd", log_a[2].i, log_a[2].d, log_a[2].addr, log_a[2].data); end
        end
        checks++; if ({done_a, core_reset_a} !== 2'b10) begin errors++; $display("FAIL midrst_release: got %b required 10", {done_a, core_reset_a}); end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_gaps();
        test_wrap();
        test_empty_image();
        test_done_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
